// File: rtl/digi_ota_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : digi_ota_pkg                                                 |
// | Desc   : Shared state encoding and constants for the OTA sampler.     |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
package digi_ota_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int SETTLE_CYCLES = 4;
  localparam int SETTLE_W      = $clog2(SETTLE_CYCLES);
  localparam int DEF_WIN_LOG2  = 8;
  localparam int DEF_RES_W     = 8;

endpackage
`default_nettype wire

// File: rtl/digi_ota_sync.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : digi_ota_sync                                                |
// | Desc   : Comparator resynchroniser with optional 3-tap majority       |
// |          glitch filter (DIGI_OTA_GLITCH_FILTER_EN).                   |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module digi_ota_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

`ifdef DIGI_OTA_GLITCH_FILTER_EN
  logic [2:0] filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
    end else begin
      filt_q <= {filt_q[1:0], sync_q[SYNC_STAGES-1]};
    end
  end

  // 2-of-3 vote: a lone one-cycle pulse can never win the majority
  assign q = (filt_q[0] & filt_q[1]) |
             (filt_q[0] & filt_q[2]) |
             (filt_q[1] & filt_q[2]);
`else
  assign q = sync_q[SYNC_STAGES-1];
`endif

endmodule
`default_nettype wire

// File: rtl/digi_ota_sampler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : digi_ota_sampler                                             |
// | Desc   : Ones-density meter for the asynchronous comparator output.   |
// |          Optional glitch filter via DIGI_OTA_GLITCH_FILTER_EN.        |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module digi_ota_sampler
  import digi_ota_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WIN_LOG2    = DEF_WIN_LOG2,
  parameter int RES_W       = DEF_RES_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmp_in,
  input  logic             start,
  input  logic             continuous,
  output logic [RES_W-1:0] result,
  output logic             result_valid,
  output logic             busy
);

  localparam int ACC_W = WIN_LOG2 + 1;
  localparam int CMP_W = (ACC_W > RES_W) ? ACC_W : RES_W;
  localparam logic [CMP_W-1:0] RES_MAX = CMP_W'({RES_W{1'b1}});

  state_e              state_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [ACC_W-1:0]    acc_q;
  logic [WIN_LOG2-1:0] win_q;
  logic [RES_W-1:0]    result_q;
  logic                valid_q;
  logic                busy_q;

  logic                s;
  logic [ACC_W-1:0]    acc_d;
  logic [CMP_W-1:0]    acc_ext;
  logic [RES_W-1:0]    sat_d;

  digi_ota_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmp_in),
    .q     (s)
  );

  // Count including the current sample, so the final window bit lands in result
  assign acc_d   = acc_q + ACC_W'(s);
  assign acc_ext = CMP_W'(acc_d);
  assign sat_d   = (acc_ext > RES_MAX) ? {RES_W{1'b1}} : acc_ext[RES_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      acc_q    <= '0;
      win_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && ena) begin
            state_q  <= SETTLE;
            settle_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        SETTLE: begin
          if (!ena) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            win_q   <= '0;
          end else begin
            settle_q <= settle_q + SETTLE_W'(1);
          end
        end
        ACCUM: begin
          if (!ena) begin
            state_q <= IDLE;
            acc_q   <= '0;
            win_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            win_q <= win_q + WIN_LOG2'(1);
            if (win_q == {WIN_LOG2{1'b1}}) begin
              state_q  <= DONE;
              result_q <= sat_d;
              valid_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          acc_q <= '0;
          win_q <= '0;
          if (continuous && ena) begin
            state_q <= ACCUM;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire
